// File: rtl/noc_pkg.sv
// Shared router constants and types for the SA stage.
package noc_pkg;

    localparam int unsigned PORT_NUM            = 5;
    localparam int unsigned VC_NUM              = 4;
    localparam int unsigned VC_SIZE             = $clog2(VC_NUM);
    localparam int unsigned PORT_W              = $clog2(PORT_NUM);
    localparam int unsigned SA_DOWNSTREAM_DEPTH = 8;

    typedef logic [PORT_W-1:0]  port_t;
    typedef logic [VC_SIZE-1:0] vc_t;

    localparam port_t LOCAL = port_t'(0);
    localparam port_t NORTH = port_t'(1);
    localparam port_t EAST  = port_t'(2);
    localparam port_t SOUTH = port_t'(3);
    localparam port_t WEST  = port_t'(4);

endpackage

// File: rtl/input_block2switch_allocator.sv
// Per-VC switch requests from the input blocks and the per-input VC grants back.
interface input_block2switch_allocator;
    import noc_pkg::*;

    logic [VC_NUM-1:0]   switch_request [PORT_NUM];
    port_t               out_port       [PORT_NUM][VC_NUM];
    vc_t                 downstream_vc  [PORT_NUM][VC_NUM];
    vc_t                 vc_sel         [PORT_NUM];
    logic [PORT_NUM-1:0] valid_sel;

    modport switch_allocator (
        input  switch_request, out_port, downstream_vc,
        output vc_sel, valid_sel
    );

    modport input_block (
        output switch_request, out_port, downstream_vc,
        input  vc_sel, valid_sel
    );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: combinational grant from a rotating priority pointer,
// pointer moves past the winner only when the caller confirms the grant.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             upd_i,
    output logic [N-1:0]     gnt_c_o,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             any_c_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // first requester at or after the pointer, wrapping
    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_q) + k) % N;
            if (!any_c_o && req_i[IDX_W'(j)]) begin
                any_c_o              = 1'b1;
                idx_c_o              = IDX_W'(j);
                gnt_c_o[IDX_W'(j)]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            ptr_d = (32'(idx_c_o) == N - 1) ? '0 : idx_c_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// Separable input-first round-robin switch allocator with registered crossbar selects.
// Optional downstream credit tracking enabled by SA_CREDIT_CHECK_EN.
module switch_allocator_rr
    import noc_pkg::*;
#(
    parameter int unsigned DOWNSTREAM_DEPTH = SA_DOWNSTREAM_DEPTH,
    parameter int unsigned CREDIT_W         = $clog2(DOWNSTREAM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input_block2switch_allocator.switch_allocator ib_if,
    input  logic [PORT_NUM-1:0]  credit_valid_i,
    input  vc_t                  credit_vc_i [PORT_NUM],
    output port_t                xb_sel_o    [PORT_NUM],
    output logic [PORT_NUM-1:0]  xb_valid_o,
    output logic                 credit_err_o
);

    logic [VC_NUM-1:0]   elig    [PORT_NUM];
    logic [VC_NUM-1:0]   s1_req  [PORT_NUM];
    logic [VC_NUM-1:0]   s1_gnt  [PORT_NUM];
    vc_t                 s1_idx  [PORT_NUM];
    logic [PORT_NUM-1:0] s1_any;
    port_t               cand_port [PORT_NUM];
    logic [PORT_NUM-1:0] s2_req  [PORT_NUM];
    logic [PORT_NUM-1:0] s2_gnt  [PORT_NUM];
    port_t               s2_idx  [PORT_NUM];
    logic [PORT_NUM-1:0] s2_any;
    logic [PORT_NUM-1:0] in_won;

    vc_t                 vc_sel_q   [PORT_NUM];
    vc_t                 vc_sel_d   [PORT_NUM];
    port_t               xb_sel_q   [PORT_NUM];
    port_t               xb_sel_d   [PORT_NUM];
    logic [PORT_NUM-1:0] xb_valid_q, xb_valid_d;

`ifdef SA_CREDIT_CHECK_EN
    logic [CREDIT_W-1:0] cred_q [PORT_NUM][VC_NUM];
    logic [CREDIT_W-1:0] cred_d [PORT_NUM][VC_NUM];
    vc_t                 cand_dvc [PORT_NUM];
    logic                err_q, err_d;

    // a VC is eligible only if its downstream buffer has room
    always_comb begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                elig[i][v] = 1'b0;
                if (32'(ib_if.out_port[i][v]) < PORT_NUM) begin
                    elig[i][v] = (cred_q[ib_if.out_port[i][v]][ib_if.downstream_vc[i][v]] != '0);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            cand_dvc[i] = '0;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (s1_gnt[i][v]) cand_dvc[i] = ib_if.downstream_vc[i][v];
            end
        end
    end

    // grant consumes, returned credit restores; both together cancel out
    always_comb begin
        logic inc, dec;
        inc   = 1'b0;
        dec   = 1'b0;
        err_d = err_q;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            for (int unsigned d = 0; d < VC_NUM; d++) begin
                cred_d[o][d] = cred_q[o][d];
                dec = 1'b0;
                for (int unsigned i = 0; i < PORT_NUM; i++) begin
                    if (s2_gnt[o][i] && 32'(cand_dvc[i]) == d) dec = 1'b1;
                end
                inc = credit_valid_i[o] && (32'(credit_vc_i[o]) == d);
                if (inc && !dec) begin
                    if (32'(cred_q[o][d]) >= DOWNSTREAM_DEPTH) err_d = 1'b1;
                    else cred_d[o][d] = cred_q[o][d] + CREDIT_W'(1);
                end else if (dec && !inc) begin
                    cred_d[o][d] = cred_q[o][d] - CREDIT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int unsigned o = 0; o < PORT_NUM; o++) begin
                for (int unsigned d = 0; d < VC_NUM; d++) begin
                    cred_q[o][d] <= CREDIT_W'(DOWNSTREAM_DEPTH);
                end
            end
        end else begin
            err_q  <= err_d;
            cred_q <= cred_d;
        end
    end

    assign credit_err_o = err_q;
`else
    logic                unused_inputs;
    logic [CREDIT_W-1:0] unused_depth;

    always_comb begin
        unused_inputs = ^credit_valid_i;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            elig[p]        = '1;
            unused_inputs ^= ^credit_vc_i[p];
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                unused_inputs ^= ^ib_if.downstream_vc[p][v];
            end
        end
    end

    assign unused_depth = CREDIT_W'(DOWNSTREAM_DEPTH);
    assign credit_err_o = 1'b0;
`endif

    // stage 1: one candidate VC per input; requests are ignored while in reset
    always_comb begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            s1_req[i]    = ib_if.switch_request[i] & elig[i] & {VC_NUM{rst_n}};
            cand_port[i] = '0;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (s1_gnt[i][v]) cand_port[i] = ib_if.out_port[i][v];
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in_arb
        rr_arbiter #(.N(VC_NUM)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_i   (s1_req[i]),
            .upd_i   (in_won[i]),
            .gnt_c_o (s1_gnt[i]),
            .idx_c_o (s1_idx[i]),
            .any_c_o (s1_any[i])
        );
    end

    // stage 2: one winning input per output
    always_comb begin
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            for (int unsigned i = 0; i < PORT_NUM; i++) begin
                s2_req[o][i] = s1_any[i] && (32'(cand_port[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
        rr_arbiter #(.N(PORT_NUM)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_i   (s2_req[o]),
            .upd_i   (s2_any[o]),
            .gnt_c_o (s2_gnt[o]),
            .idx_c_o (s2_idx[o]),
            .any_c_o (s2_any[o])
        );
    end

    always_comb begin
        in_won = '0;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            in_won = in_won | s2_gnt[o];
        end
    end

    // losers keep presenting the last granted VC
    always_comb begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            vc_sel_d[i]     = in_won[i] ? s1_idx[i] : vc_sel_q[i];
            ib_if.vc_sel[i] = vc_sel_d[i];
        end
        ib_if.valid_sel = in_won;
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            xb_sel_d[o] = s2_any[o] ? s2_idx[o] : xb_sel_q[o];
        end
        xb_valid_d = s2_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xb_valid_q <= '0;
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                vc_sel_q[p] <= '0;
                xb_sel_q[p] <= '0;
            end
        end else begin
            xb_valid_q <= xb_valid_d;
            vc_sel_q   <= vc_sel_d;
            xb_sel_q   <= xb_sel_d;
        end
    end

    assign xb_sel_o   = xb_sel_q;
    assign xb_valid_o = xb_valid_q;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Bench for switch_allocator_rr: directed table, random vs. reference model, credit and reset sequences.
module tb_switch_allocator_rr;
    import noc_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef SA_CREDIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [PORT_NUM-1:0] credit_valid;
    vc_t                 credit_vc [PORT_NUM];
    port_t               xb_sel    [PORT_NUM];
    logic [PORT_NUM-1:0] xb_valid;
    logic                credit_err;
    int                  checks = 0;
    int                  errors = 0;

    input_block2switch_allocator ib ();

    switch_allocator_rr #(.DOWNSTREAM_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ib_if          (ib),
        .credit_valid_i (credit_valid),
        .credit_vc_i    (credit_vc),
        .xb_sel_o       (xb_sel),
        .xb_valid_o     (xb_valid),
        .credit_err_o   (credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [VC_NUM-1:0]   req0, req1, req2;
        logic [PORT_NUM-1:0] valid;
        vc_t                 vc0, vc1, vc2;
        logic [PORT_NUM-1:0] xbv;
        port_t               xbs_e, xbs_n;
    } vec_t;

    vec_t tbl [9];

    // reference model state
    int m_in_ptr  [PORT_NUM];
    int m_out_ptr [PORT_NUM];
    int m_last_vc [PORT_NUM];
    int m_xbs     [PORT_NUM];
    bit m_xbv     [PORT_NUM];
    int m_cred    [PORT_NUM][VC_NUM];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PORT_NUM*VC_SIZE-1:0] dut_vc();
        logic [PORT_NUM*VC_SIZE-1:0] r;
        for (int i = 0; i < PORT_NUM; i++) r[i*VC_SIZE +: VC_SIZE] = ib.vc_sel[i];
        return r;
    endfunction

    function automatic logic [PORT_NUM*PORT_W-1:0] dut_xbs();
        logic [PORT_NUM*PORT_W-1:0] r;
        for (int o = 0; o < PORT_NUM; o++) r[o*PORT_W +: PORT_W] = xb_sel[o];
        return r;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < PORT_NUM; i++) begin
            ib.switch_request[i] = '0;
            credit_vc[i]         = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                ib.out_port[i][v]      = LOCAL;
                ib.downstream_vc[i][v] = vc_t'(v);
            end
        end
        credit_valid = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < PORT_NUM; p++) begin
            m_in_ptr[p] = 0; m_out_ptr[p] = 0; m_last_vc[p] = 0; m_xbs[p] = 0; m_xbv[p] = 0;
            for (int d = 0; d < VC_NUM; d++) m_cred[p][d] = DEPTH;
        end
        m_err = 0;
    endtask

    // one random cycle: predict from the allocation rules, compare, then advance the model
    task automatic model_cycle();
        int cand_v [PORT_NUM];
        int win    [PORT_NUM];
        int v, i, n;
        logic [PORT_NUM-1:0]        e_valid, e_xbv;
        logic [PORT_NUM*VC_SIZE-1:0] e_vc;
        logic [PORT_NUM*PORT_W-1:0]  e_xbs;
        for (int o = 0; o < PORT_NUM; o++) begin
            e_xbv[o] = m_xbv[o];
            e_xbs[o*PORT_W +: PORT_W] = PORT_W'(m_xbs[o]);
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            cand_v[p] = -1;
            for (int k = 0; k < VC_NUM; k++) begin
                v = (m_in_ptr[p] + k) % VC_NUM;
                if (cand_v[p] < 0 && ib.switch_request[p][v] &&
                    (!CHK || m_cred[ib.out_port[p][v]][ib.downstream_vc[p][v]] > 0))
                    cand_v[p] = v;
            end
        end
        e_valid = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            win[o] = -1;
            for (int k = 0; k < PORT_NUM; k++) begin
                i = (m_out_ptr[o] + k) % PORT_NUM;
                if (win[o] < 0 && cand_v[i] >= 0 && int'(ib.out_port[i][cand_v[i]]) == o) win[o] = i;
            end
            if (win[o] >= 0) begin
                e_valid[win[o]] = 1'b1;
                m_last_vc[win[o]] = cand_v[win[o]];
            end
        end
        for (int p = 0; p < PORT_NUM; p++) e_vc[p*VC_SIZE +: VC_SIZE] = VC_SIZE'(m_last_vc[p]);

        chk("rnd_valid_sel", 32'(ib.valid_sel), 32'(e_valid));
        chk("rnd_vc_sel", 32'(dut_vc()), 32'(e_vc));
        chk("rnd_xb_valid", 32'(xb_valid), 32'(e_xbv));
        chk("rnd_xb_sel", 32'(dut_xbs()), 32'(e_xbs));
        chk("rnd_credit_err", 32'(credit_err), 32'(m_err));

        for (int o = 0; o < PORT_NUM; o++) begin
            m_xbv[o] = (win[o] >= 0);
            if (win[o] >= 0) begin
                m_xbs[o] = win[o];
                m_out_ptr[o] = (win[o] + 1) % PORT_NUM;
                m_in_ptr[win[o]] = (cand_v[win[o]] + 1) % VC_NUM;
            end
            if (CHK) begin
                for (int d = 0; d < VC_NUM; d++) begin
                    n = m_cred[o][d];
                    if (credit_valid[o] && int'(credit_vc[o]) == d) n++;
                    if (win[o] >= 0 && int'(ib.downstream_vc[win[o]][cand_v[win[o]]]) == d) n--;
                    if (n > int'(DEPTH)) begin
                        m_err = 1'b1;
                        n = DEPTH;
                    end
                    m_cred[o][d] = n;
                end
            end
        end
    endtask

    // input 0 requests VC0 to EAST with downstream VC1; optional credit on EAST
    task automatic hand(input string name, input bit req, input bit cred, input vc_t cvc,
                        input bit exp_v, input bit exp_err);
        ib.switch_request[0]   = req ? 4'b0001 : 4'b0000;
        ib.out_port[0][0]      = EAST;
        ib.downstream_vc[0][0] = vc_t'(1);
        credit_valid           = '0;
        credit_valid[EAST]     = cred;
        credit_vc[EAST]        = cvc;
        #1;
        chk({name, "_valid"}, 32'(ib.valid_sel[0]), 32'(exp_v));
        chk({name, "_err"}, 32'(credit_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{4'b0011, 4'b0000, 4'b0000, 5'b00001, 2'd0, 2'd0, 2'd0, 5'b00000, 3'd0, 3'd0};
        tbl[1] = '{4'b0011, 4'b0000, 4'b0000, 5'b00001, 2'd1, 2'd0, 2'd0, 5'b00100, 3'd0, 3'd0};
        tbl[2] = '{4'b0011, 4'b0000, 4'b0000, 5'b00001, 2'd0, 2'd0, 2'd0, 5'b00100, 3'd0, 3'd0};
        tbl[3] = '{4'b0000, 4'b0001, 4'b0010, 5'b00010, 2'd0, 2'd0, 2'd0, 5'b00100, 3'd0, 3'd0};
        tbl[4] = '{4'b0000, 4'b0001, 4'b0010, 5'b00100, 2'd0, 2'd0, 2'd1, 5'b00010, 3'd0, 3'd1};
        tbl[5] = '{4'b0000, 4'b0001, 4'b0010, 5'b00010, 2'd0, 2'd0, 2'd1, 5'b00010, 3'd0, 3'd2};
        tbl[6] = '{4'b0000, 4'b0001, 4'b0010, 5'b00100, 2'd0, 2'd0, 2'd1, 5'b00010, 3'd0, 3'd1};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 5'b00000, 2'd0, 2'd0, 2'd1, 5'b00010, 3'd0, 3'd2};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 5'b00000, 2'd0, 2'd0, 2'd1, 5'b00000, 3'd0, 3'd2};

        clear_inputs();
        ib.switch_request[1] = 4'b1111;
        #12;
        chk("rst_valid_sel", 32'(ib.valid_sel), 32'd0);
        chk("rst_vc_sel", 32'(dut_vc()), 32'd0);
        chk("rst_xb_valid", 32'(xb_valid), 32'd0);
        chk("rst_xb_sel", 32'(dut_xbs()), 32'd0);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        do_reset();

        // directed: no-contention VC alternation, then NORTH contention between inputs 1 and 2
        for (int r = 0; r < 9; r++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                ib.out_port[0][v] = EAST;
                ib.out_port[1][v] = NORTH;
                ib.out_port[2][v] = NORTH;
            end
            ib.switch_request[0] = tbl[r].req0;
            ib.switch_request[1] = tbl[r].req1;
            ib.switch_request[2] = tbl[r].req2;
            #1;
            chk($sformatf("tbl%0d_valid_sel", r), 32'(ib.valid_sel), 32'(tbl[r].valid));
            chk($sformatf("tbl%0d_vc_sel", r), 32'(dut_vc()),
                32'({2'd0, 2'd0, tbl[r].vc2, tbl[r].vc1, tbl[r].vc0}));
            chk($sformatf("tbl%0d_xb_valid", r), 32'(xb_valid), 32'(tbl[r].xbv));
            chk($sformatf("tbl%0d_xb_sel_east", r), 32'(xb_sel[EAST]), 32'(tbl[r].xbs_e));
            chk($sformatf("tbl%0d_xb_sel_north", r), 32'(xb_sel[NORTH]), 32'(tbl[r].xbs_n));
            @(negedge clk);
        end

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                ib.switch_request[p] = VC_NUM'($urandom_range(0, 15));
                for (int v = 0; v < VC_NUM; v++) begin
                    ib.out_port[p][v]      = port_t'($urandom_range(0, PORT_NUM - 1));
                    ib.downstream_vc[p][v] = vc_t'($urandom_range(0, VC_NUM - 1));
                end
                credit_valid[p] = ($urandom_range(0, 2) == 0);
                credit_vc[p]    = vc_t'($urandom_range(0, VC_NUM - 1));
            end
            #1;
            model_cycle();
            @(negedge clk);
        end

        // credit exhaustion, return, simultaneous grant+credit, overflow
        do_reset();
        hand("cr_a1", 1, 0, 0, 1, 0);
        hand("cr_a2", 1, 0, 0, 1, 0);
        hand("cr_a3", 1, 0, 0, !CHK, 0);
        hand("cr_a4", 0, 1, 1, 0, 0);
        hand("cr_a5", 1, 0, 0, 1, 0);
        hand("cr_b1", 0, 1, 1, 0, 0);
        hand("cr_b2", 1, 1, 1, 1, 0);
        hand("cr_b3", 1, 0, 0, 1, 0);
        hand("cr_b4", 1, 0, 0, !CHK, 0);
        hand("cr_c1", 0, 1, 0, 0, 0);
        hand("cr_c2", 0, 0, 0, 0, CHK);
        hand("cr_c3", 0, 0, 0, 0, CHK);
        hand("cr_c4", 0, 0, 0, 0, CHK);

        // asynchronous reset mid-stream with pointers moved and grants pending
        clear_inputs();
        ib.downstream_vc[0][1] = vc_t'(0);
        for (int v = 0; v < VC_NUM; v++) begin
            ib.out_port[0][v] = EAST;
            ib.out_port[1][v] = NORTH;
            ib.out_port[2][v] = NORTH;
        end
        ib.switch_request[0] = 4'b0011;
        ib.switch_request[1] = 4'b0001;
        ib.switch_request[2] = 4'b0010;
        #1;
        chk("mr_pre_valid_sel", 32'(ib.valid_sel), 32'h03);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid_sel", 32'(ib.valid_sel), 32'd0);
        chk("mr_vc_sel", 32'(dut_vc()), 32'd0);
        chk("mr_xb_valid", 32'(xb_valid), 32'd0);
        chk("mr_xb_sel", 32'(dut_xbs()), 32'd0);
        chk("mr_credit_err", 32'(credit_err), 32'd0);
        @(posedge clk);
        #1;
        chk("mr_hold_valid_sel", 32'(ib.valid_sel), 32'd0);
        chk("mr_hold_xb_valid", 32'(xb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_post_valid_sel", 32'(ib.valid_sel), 32'h03);
        chk("mr_post_vc_sel", 32'(dut_vc()), 32'd0);
        @(negedge clk);
        for (int p = 0; p < PORT_NUM; p++) ib.switch_request[p] = '0;
        credit_valid[EAST] = 1'b1;
        credit_vc[EAST]    = vc_t'(1);
        #1;
        chk("mr_post_xb_valid", 32'(xb_valid), 32'h06);
        chk("mr_post_xb_sel", 32'(dut_xbs()), 32'h08);
        @(negedge clk);
        credit_valid = '0;
        #1;
        chk("mr_post_credit_full", 32'(credit_err), 32'(CHK));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
